// File: rtl/i2c_slave_regbank_if.sv
// Byte-level handshake between the I2C slave engine and the register-bank driver.
interface i2c_slave_regbank_if;
  logic [6:0] address;
  logic [7:0] datareceive;
  logic       received;
  logic [7:0] datasend;
  logic       sended;
  logic       stop;

  // master: the slave engine; slave: the register-bank driver
  modport master (input address, datasend, output datareceive, received, sended, stop);
  modport slave  (output address, datasend, input datareceive, received, sended, stop);
endinterface

// File: rtl/i2c_slave_regbank.sv
// 16 x 8 register bank behind an I2C slave engine: pointer byte, auto-increment with
// wrap, read-only status register 15, local side port and end-of-write interrupt.
module i2c_slave_regbank #(
  parameter logic [6:0] SLAVE_ADDR = 7'h27,
  parameter logic [7:0] RESET_R0   = 8'h00
) (
  input  logic                       clk,
  input  logic                       reset,
  i2c_slave_regbank_if.slave         bus,
  input  logic                       lwe,
  input  logic [3:0]                 laddr,
  input  logic [7:0]                 ldata,
  output logic [7:0]                 lq,
  input  logic [7:0]                 status_in,
  output logic [7:0]                 ctrl,
  output logic                       irq,
  output logic [3:0]                 ptr
);

  typedef enum logic {ST_PTR, ST_DATA} state_t;

  state_t     state, state_nxt;
  logic [3:0] ptr_nxt;
  logic       wrote, wrote_nxt;
  logic       irq_nxt;
  logic       i2c_we;
  logic [7:0] regs     [0:14];
  logic [7:0] regs_nxt [0:14];
  logic [7:0] ds_nxt;

  assign bus.address = SLAVE_ADDR;
  assign ctrl        = regs[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_PTR;
      ptr   <= '0;
      wrote <= 1'b0;
      irq   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      wrote <= wrote_nxt;
      irq   <= irq_nxt;
    end
  end

  // received takes priority over sended; stop is applied after the byte so irq sees its write
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wrote_nxt = wrote;
    irq_nxt   = 1'b0;
    i2c_we    = 1'b0;
    if (bus.received) begin
      if (state == ST_PTR) begin
        ptr_nxt   = bus.datareceive[3:0];
        state_nxt = ST_DATA;
      end else begin
        i2c_we    = (ptr != 4'hF);
        ptr_nxt   = ptr + 4'd1;
        wrote_nxt = 1'b1;
      end
    end else if (bus.sended) begin
      ptr_nxt = ptr + 4'd1;
    end
    if (bus.stop) begin
      state_nxt = ST_PTR;
      irq_nxt   = wrote_nxt;
      wrote_nxt = 1'b0;
    end
  end

  // Index 15 has no storage, so writes to it fall away; the I2C write overrides a local one
  always_comb begin
    for (int unsigned i = 0; i < 15; i++) begin
      regs_nxt[i] = regs[i];
      if (lwe && laddr == 4'(i))
        regs_nxt[i] = ldata;
      if (i2c_we && ptr == 4'(i))
        regs_nxt[i] = bus.datareceive;
    end
  end

  always_comb begin
    ds_nxt = status_in;
    for (int unsigned i = 0; i < 15; i++)
      if (ptr_nxt == 4'(i))
        ds_nxt = regs_nxt[i];
  end

  always_comb begin
    lq = status_in;
    for (int unsigned i = 0; i < 15; i++)
      if (laddr == 4'(i))
        lq = regs[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 15; i++)
        regs[i] <= (i == 0) ? RESET_R0 : '0;
      bus.datasend <= RESET_R0;
    end else begin
      for (int unsigned i = 0; i < 15; i++)
        regs[i] <= regs_nxt[i];
      bus.datasend <= ds_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed and randomized checks of i2c_slave_regbank against a behavioural register-file model.
module tb_i2c_slave_regbank;

  localparam logic [7:0] R0 = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic       lwe;
  logic [3:0] laddr;
  logic [7:0] ldata;
  logic [7:0] lq;
  logic [7:0] status_in;
  logic [7:0] ctrl;
  logic       irq;
  logic [3:0] ptr;

  i2c_slave_regbank_if bus ();

  i2c_slave_regbank #(.SLAVE_ADDR(7'h27), .RESET_R0(R0)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .lwe(lwe), .laddr(laddr), .ldata(ldata), .lq(lq),
    .status_in(status_in), .ctrl(ctrl), .irq(irq), .ptr(ptr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  int         m_ptr;
  bit         m_in_data;
  bit         m_wrote;
  logic       exp_irq;
  logic [7:0] exp_ds;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input int idx);
    return (idx == 15) ? status_in : mem[idx];
  endfunction

  task automatic model_reset();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0]    = R0;
    m_ptr     = 0;
    m_in_data = 0;
    m_wrote   = 0;
    exp_irq   = 1'b0;
    exp_ds    = R0;
  endtask

  task automatic model_edge(input logic r, input logic [7:0] d, input logic s, input logic p,
                            input logic lw, input logic [3:0] la, input logic [7:0] ld);
    if (lw && la != 4'd15) mem[la] = ld;
    if (r) begin
      if (!m_in_data) begin
        m_ptr     = int'(d[3:0]);
        m_in_data = 1;
      end else begin
        if (m_ptr != 15) mem[m_ptr] = d;
        m_ptr   = (m_ptr + 1) % 16;
        m_wrote = 1;
      end
    end else if (s) begin
      m_ptr = (m_ptr + 1) % 16;
    end
    exp_irq = p && m_wrote;
    if (p) begin
      m_in_data = 0;
      m_wrote   = 0;
    end
    exp_ds = model_read(m_ptr);
  endtask

  task automatic check_outs();
    int la;
    la    = int'($urandom_range(0, 15));
    laddr = 4'(la);
    #1;
    chk("irq", irq, exp_irq);
    chk("ptr", ptr, 8'(m_ptr));
    chk("ctrl", ctrl, mem[0]);
    chk("datasend", bus.datasend, exp_ds);
    chk("lq", lq, model_read(la));
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    model_edge(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    check_outs();
  endtask

  // One event cycle followed by one quiet cycle (byte events are at least 2 cycles apart)
  task automatic ev(input logic r, input logic [7:0] d, input logic s, input logic p,
                    input logic lw, input logic [3:0] la, input logic [7:0] ld);
    bus.received = r; bus.datareceive = d; bus.sended = s; bus.stop = p;
    lwe = lw; laddr = la; ldata = ld;
    @(posedge clk);
    model_edge(r, d, s, p, lw, la, ld);
    @(negedge clk);
    bus.received = 1'b0; bus.sended = 1'b0; bus.stop = 1'b0; lwe = 1'b0;
    check_outs();
    idle_cycle();
  endtask

  task automatic wr(input logic [7:0] d);   ev(1'b1, d, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00); endtask
  task automatic stp();                     ev(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00); endtask
  task automatic snd();                     ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00); endtask
  task automatic lwr(input logic [3:0] a, input logic [7:0] v); ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a, v); endtask

  task automatic set_status(input logic [7:0] v);
    status_in = v;
    idle_cycle();
  endtask

  task automatic chk_lq(input string tag, input logic [3:0] a, input logic [7:0] exp);
    laddr = a;
    #1;
    chk(tag, lq, exp);
  endtask

  initial begin
    int kind;
    logic [7:0] d;
    logic [3:0] la;
    reset = 1'b0;
    bus.received = 1'b0; bus.sended = 1'b0; bus.stop = 1'b0; bus.datareceive = 8'h00;
    lwe = 1'b0; laddr = 4'h0; ldata = 8'h00; status_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ctrl", ctrl, R0);
    chk("rst_datasend", bus.datasend, R0);
    chk("rst_ptr", ptr, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("address", 8'(bus.address), 8'h27);
    chk_lq("rst_lq5", 4'd5, 8'h00);

    // Pointer then two writes then stop
    wr(8'h03); wr(8'hA5); wr(8'h3C);
    chk_lq("reg3", 4'd3, 8'hA5);
    chk_lq("reg4", 4'd4, 8'h3C);
    chk("ptr5", ptr, 8'h05);
    stp();

    // Wrap and read-only register 15
    set_status(8'h5A);
    wr(8'hFE); wr(8'h11); wr(8'h22); wr(8'h33);
    chk_lq("reg14", 4'd14, 8'h11);
    chk_lq("reg15", 4'd15, 8'h5A);
    chk_lq("reg0", 4'd0, 8'h33);
    chk("ctrl33", ctrl, 8'h33);
    chk("ptr1", ptr, 8'h01);
    stp();

    // Read burst after a pointer-only transaction
    lwr(4'd7, 8'h77); lwr(4'd8, 8'h88); lwr(4'd9, 8'h99);
    wr(8'h07);
    chk("burst0", bus.datasend, 8'h77);
    stp();
    chk("no_irq_ptr_only", irq, 1'b0);
    snd();
    chk("burst1", bus.datasend, 8'h88);
    snd();
    chk("burst2", bus.datasend, 8'h99);

    // Collision of I2C and local writes
    wr(8'h02);
    ev(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 4'd2, 8'h0F);
    chk_lq("coll_same", 4'd2, 8'hC3);
    stp();
    wr(8'h02);
    ev(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 4'd6, 8'h0F);
    chk_lq("coll_diff2", 4'd2, 8'hC3);
    chk_lq("coll_diff6", 4'd6, 8'h0F);
    stp();

    // Reset in the middle of a write transaction
    wr(8'h09); wr(8'hEE);
    chk_lq("pre_rst_reg9", 4'd9, 8'hEE);
    reset = 1'b0;
    #2 model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_outs();
    chk_lq("rst_reg9", 4'd9, 8'h00);
    stp();
    chk("no_irq_after_rst", irq, 1'b0);
    wr(8'h05);
    chk("fsm_ptr_after_rst", ptr, 8'h05);
    chk_lq("no_write_after_rst", 4'd5, 8'h00);
    stp();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      d    = 8'($urandom);
      la   = ($urandom_range(0, 1) == 1) ? 4'(m_ptr) : 4'($urandom);
      case (kind)
        0, 1, 2: wr(d);
        3:       snd();
        4:       stp();
        5:       ev(1'b1, d, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00);
        6:       ev(1'b1, d, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        7:       ev(1'b1, d, 1'b0, 1'b0, 1'b1, la, 8'($urandom));
        8:       lwr(la, 8'($urandom));
        default: set_status(8'($urandom));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
